// File: rtl/button_conditioner_pkg.sv
// ============================================================================
// Module  : button_conditioner_pkg
// Brief   : Shared button indices, keyboard-select encodings and reset FSM states.
// Revision: 1.0
// ============================================================================
`default_nettype none

package button_conditioner_pkg;

    localparam int c_btn_reset = 0;
    localparam int c_btn_cls   = 1;
    localparam int c_btn_ps2   = 2;

    localparam logic c_sel_ps2  = 1'b1;
    localparam logic c_sel_uart = 1'b0;

    localparam logic [0:0] c_st_assert = 1'b0;
    localparam logic [0:0] c_st_run    = 1'b1;

endpackage

`default_nettype wire

// File: rtl/button_conditioner_debounce_channel.sv
// ============================================================================
// Module  : debounce_channel
// Brief   : Two-flop synchroniser, stable-count debouncer and edge pulses for one button.
// Revision: 1.0
// ============================================================================
`default_nettype none

module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_WIDTH       = 18
) (
    input  logic clk25,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam logic [CNT_WIDTH-1:0] c_cnt_last = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_level;
    logic                 r_press;
    logic                 r_release;
    logic                 w_s;

    // Pin is active-low; work in active-high after the synchroniser.
    assign w_s = ~r_sync2;

    always_ff @(posedge clk25) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= btn_in;
            r_sync2   <= r_sync1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (w_s == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_level   <= w_s;
                r_cnt     <= '0;
                r_press   <= w_s;
                r_release <= ~w_s;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
// ============================================================================
// Module  : button_conditioner
// Brief   : Debounced buttons, core reset generator, clear-screen level and PS/2/UART select.
// Revision: 1.0
// ============================================================================
`default_nettype none

module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int   NUM_BUTTONS       = 4,
    parameter int   DEBOUNCE_CYCLES   = 250000,
    parameter int   CNT_WIDTH         = 18,
    parameter int   RESET_HOLD_CYCLES = 16,
    parameter logic PS2_SELECT_INIT   = c_sel_ps2
) (
    input  logic                   clk25,
    input  logic                   rst,
    input  logic [NUM_BUTTONS-1:0] button,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] btn_press,
    output logic [NUM_BUTTONS-1:0] btn_release,
    output logic                   rst_n_out,
    output logic                   vga_cls,
    output logic                   ps2_select
);

    localparam int                   c_hold_w    = $clog2(RESET_HOLD_CYCLES + 1);
    localparam logic [c_hold_w-1:0]  c_hold_init = c_hold_w'(RESET_HOLD_CYCLES);
    localparam logic [c_hold_w-1:0]  c_hold_one  = c_hold_w'(1);

    logic [NUM_BUTTONS-1:0] w_level;
    logic [NUM_BUTTONS-1:0] w_press;
    logic [NUM_BUTTONS-1:0] w_release;
    logic [NUM_BUTTONS-1:0] w_mask;
    logic [0:0]             r_state;
    logic [0:0]             w_state_next;
    logic [c_hold_w-1:0]    r_hold;
    logic [c_hold_w-1:0]    w_hold_next;
    logic                   w_rst_n;
    logic                   r_ps2;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_channel
            debounce_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_WIDTH       (CNT_WIDTH)
            ) u_channel (
                .clk25       (clk25),
                .rst         (rst),
                .btn_in      (button[gi]),
                .btn_level   (w_level[gi]),
                .btn_press   (w_press[gi]),
                .btn_release (w_release[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk25) begin
        if (rst) begin
            r_state <= c_st_assert;
            r_hold  <= c_hold_init;
        end else begin
            r_state <= w_state_next;
            r_hold  <= w_hold_next;
        end
    end

    // Leaving ASSERT on the last decrement keeps the core in reset for exactly the hold count.
    always_comb begin
        w_state_next = r_state;
        w_hold_next  = r_hold;
        case (r_state)
            c_st_assert: begin
                if (w_level[c_btn_reset]) begin
                    w_hold_next = c_hold_init;
                end else if (r_hold <= c_hold_one) begin
                    w_state_next = c_st_run;
                    w_hold_next  = '0;
                end else begin
                    w_hold_next = r_hold - c_hold_one;
                end
            end
            c_st_run: begin
                if (w_level[c_btn_reset]) begin
                    w_state_next = c_st_assert;
                    w_hold_next  = c_hold_init;
                end
            end
            default: begin
                w_state_next = c_st_assert;
                w_hold_next  = c_hold_init;
            end
        endcase
    end

    // An accepted reset press pulls the core into reset in the same cycle its level rises.
    always_comb begin
        w_rst_n = (r_state == c_st_run) && !w_level[c_btn_reset];
    end

    assign w_mask = {{(NUM_BUTTONS-1){w_rst_n}}, 1'b1};

    always_ff @(posedge clk25) begin
        if (rst) begin
            r_ps2 <= PS2_SELECT_INIT;
        end else if (btn_press[c_btn_ps2]) begin
            r_ps2 <= ~r_ps2;
        end
    end

    assign btn_level   = w_level;
    assign btn_press   = w_press & w_mask;
    assign btn_release = w_release & w_mask;
    assign rst_n_out   = w_rst_n;
    assign vga_cls     = w_level[c_btn_cls];
    assign ps2_select  = r_ps2;

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ============================================================================
// Module  : tb_button_conditioner
// Brief   : Randomised and directed stimulus against a stable-window reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_button_conditioner;

    localparam int NB   = 4;
    localparam int D    = 8;
    localparam int H    = 4;
    localparam int MAXC = 4000;

    logic          clk25 = 1'b0;
    logic          rst;
    logic [NB-1:0] button;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic          rst_n_out;
    logic          vga_cls;
    logic          ps2_select;

    typedef struct {
        int            cyc;
        logic [NB-1:0] level;
        logic [NB-1:0] press;
        logic [NB-1:0] rel;
        logic          rst_n;
        logic          cls;
        logic          ps2;
    } exp_t;

    exp_t sb_q[$];

    bit [NB-1:0] pin_h [MAXC];
    bit          rst_h [MAXC];
    bit [NB-1:0] lvl_h [MAXC];
    bit          p2_h  [MAXC];
    bit          ps2_h [MAXC];
    int          cyc      = 0;
    int          last_rst = -1;
    int          n_checks = 0;
    int          n_fail   = 0;

    button_conditioner #(
        .NUM_BUTTONS       (NB),
        .DEBOUNCE_CYCLES   (D),
        .CNT_WIDTH         (4),
        .RESET_HOLD_CYCLES (H),
        .PS2_SELECT_INIT   (1'b1)
    ) dut (
        .clk25       (clk25),
        .rst         (rst),
        .button      (button),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .rst_n_out   (rst_n_out),
        .vga_cls     (vga_cls),
        .ps2_select  (ps2_select)
    );

    always #5 clk25 = ~clk25;

    // Active-high button state the design sees at edge j (two-cycle synchroniser, released after rst).
    function automatic bit samp(int j, int i);
        if (j < 2) return 1'b0;
        if (rst_h[j-1] || rst_h[j-2]) return 1'b0;
        return ~pin_h[j-2][i];
    endfunction

    task automatic step(input bit r, input logic [NB-1:0] b);
        exp_t        e;
        bit [NB-1:0] prev;
        bit          flip;
        int          k;
        @(negedge clk25);
        if (cyc >= MAXC) begin
            $display("FAIL history_overflow cycle %0d: got %0d required < %0d", cyc, cyc, MAXC);
            $fatal(1);
        end
        rst    = r;
        button = b;
        k      = cyc;
        pin_h[k] = b;
        rst_h[k] = r;
        prev     = (k > 0) ? lvl_h[k-1] : '0;
        e.cyc    = k;
        e.press  = '0;
        e.rel    = '0;
        if (r) begin
            last_rst = k;
            e.level  = '0;
            e.rst_n  = 1'b0;
            e.ps2    = 1'b1;
        end else begin
            e.level = prev;
            // A level change is accepted once the input has differed for D consecutive edges since rst.
            for (int i = 0; i < NB; i++) begin
                flip = (k - D + 1) > last_rst;
                for (int j = k - D + 1; j <= k; j++)
                    if (flip && samp(j, i) == prev[i]) flip = 1'b0;
                if (flip) begin
                    e.level[i] = ~prev[i];
                    e.press[i] = ~prev[i];
                    e.rel[i]   = prev[i];
                end
            end
            // Core runs only after H edges free of rst with the reset button released beforehand.
            e.rst_n = !e.level[0];
            for (int j = k - H + 1; j <= k; j++)
                if (j <= last_rst || (j > 0 && lvl_h[j-1][0])) e.rst_n = 1'b0;
            if (!e.rst_n) begin
                e.press[NB-1:1] = '0;
                e.rel[NB-1:1]   = '0;
            end
            e.ps2 = (k > 0 && p2_h[k-1]) ? ~ps2_h[k-1] : ps2_h[k-1];
        end
        e.cls    = e.level[1];
        lvl_h[k] = e.level;
        p2_h[k]  = e.press[2];
        ps2_h[k] = e.ps2;
        sb_q.push_back(e);
        cyc++;
    endtask

    task automatic check(input string name, input int c, input logic [NB-1:0] act, input logic [NB-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b required %b", name, c, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk25);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("btn_level",   e.cyc, btn_level,          e.level);
                check("btn_press",   e.cyc, btn_press,          e.press);
                check("btn_release", e.cyc, btn_release,        e.rel);
                check("rst_n_out",   e.cyc, {3'b000, rst_n_out},  {3'b000, e.rst_n});
                check("vga_cls",     e.cyc, {3'b000, vga_cls},    {3'b000, e.cls});
                check("ps2_select",  e.cyc, {3'b000, ps2_select}, {3'b000, e.ps2});
            end
        end
    end

    initial begin : stimulus
        logic [NB-1:0] cur;
        int            dur;
        rst    = 1'b1;
        button = '1;
        repeat (3)  step(1'b1, 4'b1111);
        repeat (10) step(1'b0, 4'b1111);
        // Short glitch on clear-screen
        repeat (5)  step(1'b0, 4'b1101);
        repeat (15) step(1'b0, 4'b1111);
        // Keyboard toggle press and release
        repeat (20) step(1'b0, 4'b1011);
        repeat (20) step(1'b0, 4'b1111);
        // Reset button together with keyboard toggle
        repeat (20) step(1'b0, 4'b1010);
        repeat (25) step(1'b0, 4'b1111);
        // Clear-screen held across a button reset
        repeat (15) step(1'b0, 4'b1101);
        repeat (20) step(1'b0, 4'b1100);
        repeat (25) step(1'b0, 4'b1101);
        repeat (20) step(1'b0, 4'b1111);
        // rst in the middle of a button 3 debounce
        repeat (8)  step(1'b0, 4'b0111);
        repeat (2)  step(1'b1, 4'b0111);
        repeat (15) step(1'b0, 4'b0111);
        repeat (15) step(1'b0, 4'b1111);
        // Random segments
        cur = '1;
        for (int s = 0; s < 120; s++) begin
            for (int i = 0; i < NB; i++)
                if ($urandom_range(0, 2) == 0) cur[i] = ~cur[i];
            if ($urandom_range(0, 19) == 0)
                repeat ($urandom_range(1, 3)) step(1'b1, cur);
            dur = $urandom_range(1, 16);
            repeat (dur) step(1'b0, cur);
        end
        repeat (20) step(1'b0, 4'b1111);
        repeat (3) @(posedge clk25);
        #3;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
